// File: rtl/qoi_pkg.sv
// Shared QOI definitions: chunk tags, pixel type, FSM state encodings and the
// colour hash that picks the index slot.
package qoi_pkg;

  localparam logic [1:0] OP_INDEX = 2'b00;
  localparam logic [1:0] OP_DIFF  = 2'b01;
  localparam logic [1:0] OP_LUMA  = 2'b10;
  localparam logic [1:0] OP_RUN   = 2'b11;
  localparam logic [7:0] OP_RGB   = 8'hFE;
  localparam logic [7:0] OP_RGBA  = 8'hFF;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] a;
  } pixel_t;

  typedef enum logic [1:0] {OP, ARGS, EMIT, RUN} state_t;
  typedef enum logic [1:0] {ARG_RGB, ARG_RGBA, ARG_LUMA} arg_t;

  // Only the low six bits survive the mod 64, so 8-bit wrapping products suffice.
  function automatic logic [5:0] qoi_hash(input pixel_t p);
    logic [7:0] sum;
    sum = p.r * 8'd3 + p.g * 8'd5 + p.b * 8'd7 + p.a * 8'd11;
    return sum[5:0];
  endfunction

endpackage

// File: rtl/qoi_if.sv
// Byte-in / pixel-out stream bundle between a QOI chunk source, the decoder
// and the pixel consumer.
interface qoi_if;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] px_r;
  logic [7:0] px_g;
  logic [7:0] px_b;
  logic [7:0] px_a;
  logic       px_valid;
  logic       px_ready;

  modport master (
    output in_byte, in_valid, px_ready,
    input  in_ready, px_r, px_g, px_b, px_a, px_valid
  );

  modport slave (
    input  in_byte, in_valid, px_ready,
    output in_ready, px_r, px_g, px_b, px_a, px_valid
  );
endinterface

// File: rtl/qoi_index_ram.sv
// 64-entry colour index: one synchronous write port, one combinational read
// port, cleared asynchronously by reset.
module qoi_index_ram
  import qoi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [5:0] waddr,
  input  pixel_t     wdata,
  input  logic [5:0] raddr,
  output pixel_t     rdata
);

  pixel_t mem [64];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A write lands on the edge, so an INDEX op in the following cycle reads it.
  assign rdata = mem[raddr];

endmodule

// File: rtl/qoi_decoder.sv
// QOI chunk-stream decoder: consumes op/argument bytes and emits one RGBA
// pixel per handshake, expanding runs from the previous pixel.
module qoi_decoder
  import qoi_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  qoi_if.slave   bus,
  output logic   idle
);

  state_t      state, nxt;
  arg_t        arg_sel;
  logic [1:0]  arg_idx;
  logic [7:0]  luma0;
  logic [5:0]  run_cnt;
  logic        armed;
  pixel_t      prev, px, acc, acc_nxt, new_px, idx_rd;
  logic        in_rdy, take, load_px, last_arg;

  function automatic pixel_t diff_px(input pixel_t p, input logic [7:0] op);
    diff_px   = p;
    diff_px.r = p.r + {6'd0, op[5:4]} - 8'd2;
    diff_px.g = p.g + {6'd0, op[3:2]} - 8'd2;
    diff_px.b = p.b + {6'd0, op[1:0]} - 8'd2;
  endfunction

  function automatic pixel_t luma_px(input pixel_t p, input logic [7:0] b0,
                                     input logic [7:0] b1);
    logic [7:0] vg;
    vg        = {2'd0, b0[5:0]} - 8'd32;
    luma_px   = p;
    luma_px.g = p.g + vg;
    luma_px.r = p.r + vg + {4'd0, b1[7:4]} - 8'd8;
    luma_px.b = p.b + vg + {4'd0, b1[3:0]} - 8'd8;
  endfunction

  qoi_index_ram u_index (
    .clk   (clk),
    .rst   (rst),
    .we    (load_px),
    .waddr (qoi_hash(new_px)),
    .wdata (new_px),
    .raddr (bus.in_byte[5:0]),
    .rdata (idx_rd)
  );

  // armed holds in_ready low through reset and for nothing longer.
  assign in_rdy = armed && (state == OP || state == ARGS);
  assign take   = bus.in_valid && in_rdy;

  always_comb begin
    nxt      = state;
    load_px  = 1'b0;
    new_px   = prev;
    acc_nxt  = acc;
    last_arg = 1'b0;
    case (arg_idx)
      2'd0:    acc_nxt.r = bus.in_byte;
      2'd1:    acc_nxt.g = bus.in_byte;
      2'd2:    acc_nxt.b = bus.in_byte;
      default: acc_nxt.a = bus.in_byte;
    endcase
    case (state)
      OP: if (take) begin
        if (bus.in_byte == OP_RGB || bus.in_byte == OP_RGBA) begin
          nxt = ARGS;
        end else begin
          case (bus.in_byte[7:6])
            OP_INDEX: begin new_px = idx_rd; load_px = 1'b1; nxt = EMIT; end
            OP_DIFF:  begin new_px = diff_px(prev, bus.in_byte); load_px = 1'b1; nxt = EMIT; end
            OP_LUMA:  nxt = ARGS;
            default:  nxt = RUN;
          endcase
        end
      end
      ARGS: if (take) begin
        last_arg = (arg_sel == ARG_LUMA) ||
                   (arg_sel == ARG_RGB  && arg_idx == 2'd2) ||
                   (arg_sel == ARG_RGBA && arg_idx == 2'd3);
        if (last_arg) begin
          new_px  = (arg_sel == ARG_LUMA) ? luma_px(prev, luma0, bus.in_byte) : acc_nxt;
          load_px = 1'b1;
          nxt     = EMIT;
        end
      end
      EMIT: if (bus.px_ready) nxt = OP;
      RUN:  if (bus.px_ready && run_cnt == 6'd0) nxt = OP;
      default: nxt = OP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= OP;
      armed   <= 1'b0;
      arg_sel <= ARG_RGB;
      arg_idx <= 2'd0;
      luma0   <= 8'd0;
      run_cnt <= 6'd0;
      acc     <= '0;
      prev    <= '{r: 8'd0, g: 8'd0, b: 8'd0, a: 8'd255};
      px      <= '0;
    end else begin
      armed <= 1'b1;
      state <= nxt;
      if (load_px) begin
        prev <= new_px;
        px   <= new_px;
      end
      case (state)
        OP: if (take) begin
          arg_idx <= 2'd0;
          acc     <= prev;
          if (bus.in_byte == OP_RGB)       arg_sel <= ARG_RGB;
          else if (bus.in_byte == OP_RGBA) arg_sel <= ARG_RGBA;
          else if (bus.in_byte[7:6] == OP_LUMA) begin
            arg_sel <= ARG_LUMA;
            luma0   <= bus.in_byte;
          end else if (bus.in_byte[7:6] == OP_RUN) begin
            run_cnt <= bus.in_byte[5:0];
            px      <= prev;
          end
        end
        ARGS: if (take) begin
          acc     <= acc_nxt;
          arg_idx <= arg_idx + 2'd1;
        end
        RUN: if (bus.px_ready && run_cnt != 6'd0) run_cnt <= run_cnt - 6'd1;
        default: ;
      endcase
    end
  end

  assign bus.in_ready = in_rdy;
  assign bus.px_valid = (state == EMIT) || (state == RUN);
  assign bus.px_r     = px.r;
  assign bus.px_g     = px.g;
  assign bus.px_b     = px.b;
  assign bus.px_a     = px.a;
  assign idle         = (state == OP);

endmodule

// File: tb/tb_qoi_decoder.sv
// Directed scoreboard bench for qoi_decoder: the driver queues expected pixels,
// a negedge monitor pops and compares on every pixel transfer.
module tb_qoi_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic idle;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [31:0] exp_q[$];
  logic        hold_prev = 1'b0;
  logic [31:0] held      = '0;

  qoi_if bus();

  qoi_decoder dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .idle (idle)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] px_now();
    return {bus.px_r, bus.px_g, bus.px_b, bus.px_a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b, input logic [7:0] a);
    exp_q.push_back({r, g, b, a});
  endtask

  // Called at posedge+1; returns at posedge+1 just after the byte transferred.
  task automatic send(input logic [7:0] b);
    int   n = 0;
    logic got;
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    do begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk);
      n++;
    end while (!got && n < 500);
    #1;
    bus.in_valid = 1'b0;
    if (!got) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || !idle) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk(name, {31'd0, idle}, 32'd1);
    chk({name, "_queue_left"}, exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bus.px_valid) begin
      chk("in_ready_while_emitting", {31'd0, bus.in_ready}, 32'd0);
      if (hold_prev) chk("stall_hold", px_now(), held);
      if (bus.px_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_pixel: got %h, expected none at %0t", px_now(), $time);
        end else begin
          chk("pixel", px_now(), exp_q.pop_front());
        end
      end
    end
    hold_prev = bus.px_valid && !bus.px_ready;
    held      = px_now();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_byte  = 8'd0;
    bus.in_valid = 1'b0;
    bus.px_ready = 1'b1;
    rst          = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_px_valid", {31'd0, bus.px_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_idle",     {31'd0, idle},         32'd1);
    chk("rst_px",       px_now(),              32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_release", {31'd0, bus.in_ready}, 32'd1);

    // DIFF +1 from reset pixel, with single-byte latency
    push(8'd1, 8'd1, 8'd1, 8'd255);
    send(8'h7F);
    chk("latency_single", {31'd0, bus.px_valid}, 32'd1);
    drain("diff_basic");

    // DIFF wrap then LUMA
    do_reset();
    push(8'd254, 8'd254, 8'd254, 8'd255);
    send(8'h40);
    push(8'd29, 8'd29, 8'd29, 8'd255);
    send(8'hBF);
    send(8'h88);
    chk("latency_multi", {31'd0, bus.px_valid}, 32'd1);
    drain("diff_luma");

    // RGB then run of 3
    do_reset();
    for (int i = 0; i < 4; i++) push(8'h10, 8'h20, 8'h30, 8'hFF);
    send(8'hFE); send(8'h10); send(8'h20); send(8'h30);
    send(8'hC2);
    drain("rgb_run");

    // RGBA then INDEX 21 recalls the RGB pixel
    push(8'd1, 8'd2, 8'd3, 8'd4);
    push(8'h10, 8'h20, 8'h30, 8'hFF);
    send(8'hFF); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h15);
    drain("rgba_index");

    // INDEX right after EMIT sees the fresh entry; other slots stay cleared
    do_reset();
    push(8'd1, 8'd1, 8'd1, 8'd255);
    send(8'h7F);
    push(8'd1, 8'd1, 8'd1, 8'd255);
    send(8'h04);
    push(8'd0, 8'd0, 8'd0, 8'd0);
    send(8'h05);
    drain("index_hazard");

    // Maximum run with a 5-cycle consumer stall
    do_reset();
    for (int i = 0; i < 62; i++) push(8'd0, 8'd0, 8'd0, 8'd255);
    send(8'hFD);
    repeat (20) @(posedge clk);
    #1;
    bus.px_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.px_ready = 1'b1;
    drain("run62_stall");

    // Reset in the middle of a run
    do_reset();
    for (int i = 0; i < 62; i++) push(8'd0, 8'd0, 8'd0, 8'd255);
    send(8'hFD);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrun_rst_px_valid", {31'd0, bus.px_valid}, 32'd0);
    chk("midrun_rst_idle",     {31'd0, idle},         32'd1);
    chk("midrun_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push(8'd1, 8'd1, 8'd1, 8'd255);
    send(8'h7F);
    drain("after_midrun_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
